// File: rtl/cascaded_updown_counter_chain_pkg.sv
// Shared constants and helpers for the cascaded up/down counter chain.
package counter_chain_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Total width of the concatenated chain.
  function automatic int total_width(input int stage_width, input int num_stages);
    return stage_width * num_stages;
  endfunction

endpackage

// File: rtl/cascaded_updown_counter_chain_if.sv
// Control/data bundle of the counter chain. The master drives controls and the slave drives results.
interface cascaded_updown_counter_chain_if #(
  parameter int STAGE_WIDTH = 16,
  parameter int NUM_STAGES  = 4,
  parameter int SEL_WIDTH   = 2
);
  logic                              enable;
  logic                              up_down;
  logic                              clear;
  logic                              load;
  logic [STAGE_WIDTH*NUM_STAGES-1:0] load_value;
  logic                              clear_overflow;
  logic [SEL_WIDTH-1:0]              stage_sel;
  logic [STAGE_WIDTH-1:0]            count_out;
  logic [STAGE_WIDTH*NUM_STAGES-1:0] full_count;
  logic [NUM_STAGES-1:0]             stage_tc;
  logic                              chain_tc;
  logic                              overflow;

  modport master (
    output enable, up_down, clear, load, load_value, clear_overflow, stage_sel,
    input  count_out, full_count, stage_tc, chain_tc, overflow
  );

  modport slave (
    input  enable, up_down, clear, load, load_value, clear_overflow, stage_sel,
    output count_out, full_count, stage_tc, chain_tc, overflow
  );
endinterface

// File: rtl/cascaded_updown_counter_chain_stage.sv
// One STAGE_WIDTH-bit up/down counter stage with a terminal flag and a gated carry/borrow-out.
module counter_stage
  import counter_chain_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cin,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] value,
  output logic             term,
  output logic             tc
);

  logic [WIDTH-1:0] value_q;

  // Terminal depends only on the register and direction, so the top can
  // build the ripple chain from it without a combinational loop through tc.
  assign term  = (up_down == DIR_UP) ? (&value_q) : (value_q == '0);
  assign tc    = cin & term;
  assign value = value_q;

  // Stage register: clear over load over count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_q <= '0;
    end else if (clear) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= load_data;
    end else if (cin) begin
      if (up_down == DIR_UP) value_q <= value_q + WIDTH'(1);
      else                   value_q <= value_q - WIDTH'(1);
    end
  end

endmodule

// File: rtl/cascaded_updown_counter_chain.sv
// Top level: NUM_STAGES cascaded counter stages, a sticky overflow flag and a registered stage readout.
module cascaded_updown_counter_chain
  import counter_chain_pkg::*;
#(
  parameter int STAGE_WIDTH = 16,
  parameter int NUM_STAGES  = 4,
  parameter int SEL_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  cascaded_updown_counter_chain_if.slave bus
);

  localparam int TOTAL = total_width(STAGE_WIDTH, NUM_STAGES);

  logic [NUM_STAGES-1:0][STAGE_WIDTH-1:0] stage_val;
  logic [NUM_STAGES-1:0]                  term;
  logic [NUM_STAGES-1:0]                  cin;
  logic [NUM_STAGES-1:0]                  tc;
  logic [TOTAL-1:0]                       full_int;
  logic [STAGE_WIDTH-1:0]                 sel_value;
  logic [STAGE_WIDTH-1:0]                 count_q;
  logic                                   overflow_q;

  // Ripple carry/borrow: each stage advances when every lower stage is terminal and enable is high.
  always_comb begin
    logic c;
    c   = bus.enable;
    cin = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      cin[i] = c;
      c      = c & term[i];
    end
  end

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    counter_stage #(.WIDTH(STAGE_WIDTH)) u_stage (
      .clk       (clk),
      .reset     (reset),
      .cin       (cin[g]),
      .up_down   (bus.up_down),
      .clear     (bus.clear),
      .load      (bus.load),
      .load_data (bus.load_value[g*STAGE_WIDTH +: STAGE_WIDTH]),
      .value     (stage_val[g]),
      .term      (term[g]),
      .tc        (tc[g])
    );
    assign full_int[g*STAGE_WIDTH +: STAGE_WIDTH] = stage_val[g];
  end

  assign bus.full_count = full_int;
  assign bus.stage_tc   = tc;
  assign bus.chain_tc   = tc[NUM_STAGES-1];

  // Readout select; out-of-range selections read as zero.
  always_comb begin
    sel_value = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (bus.stage_sel == SEL_WIDTH'(i)) sel_value = stage_val[i];
    end
  end

  // Readout register captures the pre-update stage value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= sel_value;
  end

  assign bus.count_out = count_q;

  // Sticky overflow: clear beats a wrap, a wrap beats clear_overflow, load alone leaves it alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (bus.clear) begin
      overflow_q <= 1'b0;
    end else if (tc[NUM_STAGES-1] && !bus.load) begin
      overflow_q <= 1'b1;
    end else if (bus.clear_overflow) begin
      overflow_q <= 1'b0;
    end
  end

  assign bus.overflow = overflow_q;

endmodule

// File: tb/tb_cascaded_updown_counter_chain.sv
// Directed bench for the cascaded up/down counter chain (4x16 main instance, 3x16 for out-of-range select).
module tb_cascaded_updown_counter_chain;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  cascaded_updown_counter_chain_if #(.STAGE_WIDTH(16), .NUM_STAGES(4), .SEL_WIDTH(2)) bus4 ();
  cascaded_updown_counter_chain_if #(.STAGE_WIDTH(16), .NUM_STAGES(3), .SEL_WIDTH(2)) bus3 ();

  cascaded_updown_counter_chain #(.STAGE_WIDTH(16), .NUM_STAGES(4), .SEL_WIDTH(2)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  cascaded_updown_counter_chain #(.STAGE_WIDTH(16), .NUM_STAGES(3), .SEL_WIDTH(2)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset               = 1'b0;
    bus4.enable         = 1'b1;
    bus4.up_down        = 1'b1;
    bus4.clear          = 1'b0;
    bus4.load           = 1'b0;
    bus4.load_value     = '1;
    bus4.clear_overflow = 1'b0;
    bus4.stage_sel      = 2'd0;
    bus3.enable         = 1'b0;
    bus3.up_down        = 1'b1;
    bus3.clear          = 1'b0;
    bus3.load           = 1'b0;
    bus3.load_value     = '0;
    bus3.clear_overflow = 1'b0;
    bus3.stage_sel      = 2'd0;

    // Reset held with enable high and all-ones load data
    step();
    step();
    check_val("rst_full",     bus4.full_count, 64'h0);
    check_val("rst_count",    64'(bus4.count_out), 64'h0);
    check_val("rst_ovf",      64'(bus4.overflow), 64'h0);
    check_val("rst_stage_tc", 64'(bus4.stage_tc), 64'h0);

    // Release and count up 5
    reset = 1'b1;
    repeat (5) step();
    check_val("up5_full",     bus4.full_count, 64'h5);
    check_val("up5_stage_tc", 64'(bus4.stage_tc), 64'h0);

    // Stage 0 carry into stage 1
    bus4.enable     = 1'b0;
    bus4.load       = 1'b1;
    bus4.load_value = 64'h0000_0000_0000_FFFF;
    step();
    bus4.load   = 1'b0;
    bus4.enable = 1'b1;
    #1;
    check_val("carry_stage_tc", 64'(bus4.stage_tc), 64'h1);
    check_val("carry_chain_tc", 64'(bus4.chain_tc), 64'h0);
    step();
    check_val("carry_full", bus4.full_count, 64'h0000_0000_0001_0000);
    check_val("carry_ovf",  64'(bus4.overflow), 64'h0);

    // Full wrap up from all ones
    bus4.enable     = 1'b0;
    bus4.load       = 1'b1;
    bus4.load_value = '1;
    step();
    check_val("ones_gated_tc", 64'(bus4.stage_tc), 64'h0);
    bus4.load   = 1'b0;
    bus4.enable = 1'b1;
    #1;
    check_val("wrap_up_chain_tc", 64'(bus4.chain_tc), 64'h1);
    check_val("wrap_up_stage_tc", 64'(bus4.stage_tc), 64'hF);
    step();
    check_val("wrap_up_full", bus4.full_count, 64'h0);
    check_val("wrap_up_ovf",  64'(bus4.overflow), 64'h1);
    bus4.enable         = 1'b0;
    bus4.clear_overflow = 1'b1;
    step();
    check_val("clr_ovf", 64'(bus4.overflow), 64'h0);
    bus4.clear_overflow = 1'b0;

    // Full wrap down from zero
    bus4.up_down = 1'b0;
    bus4.enable  = 1'b1;
    #1;
    check_val("wrap_dn_chain_tc", 64'(bus4.chain_tc), 64'h1);
    step();
    check_val("wrap_dn_full", bus4.full_count, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("wrap_dn_ovf",  64'(bus4.overflow), 64'h1);

    // Back to zero with overflow cleared, then wrap down with clear_overflow held
    bus4.enable         = 1'b0;
    bus4.load           = 1'b1;
    bus4.load_value     = '0;
    bus4.clear_overflow = 1'b1;
    step();
    check_val("reload0_full", bus4.full_count, 64'h0);
    check_val("reload0_ovf",  64'(bus4.overflow), 64'h0);
    bus4.load   = 1'b0;
    bus4.enable = 1'b1;
    step();
    check_val("set_beats_clrovf_full", bus4.full_count, 64'hFFFF_FFFF_FFFF_FFFF);
    check_val("set_beats_clrovf_ovf",  64'(bus4.overflow), 64'h1);
    bus4.clear_overflow = 1'b0;

    // Load alone keeps overflow
    bus4.enable     = 1'b0;
    bus4.load       = 1'b1;
    bus4.load_value = '1;
    step();
    check_val("load_keeps_ovf", 64'(bus4.overflow), 64'h1);

    // Clear and load together while the chain is terminal: clear wins everywhere
    bus4.up_down    = 1'b1;
    bus4.enable     = 1'b1;
    bus4.clear      = 1'b1;
    bus4.load       = 1'b1;
    bus4.load_value = 64'h0000_1234_0000_0000;
    step();
    check_val("clr_load_full", bus4.full_count, 64'h0);
    check_val("clr_load_ovf",  64'(bus4.overflow), 64'h0);

    // Readout mux latency and out-of-range select
    bus4.clear      = 1'b0;
    bus4.enable     = 1'b0;
    bus4.load       = 1'b1;
    bus4.load_value = 64'h0000_ABCD_0000_0000;
    bus3.load       = 1'b1;
    bus3.load_value = 48'h0003_0002_0001;
    step();
    check_val("ld3_full", 64'(bus3.full_count), 64'h0000_0003_0002_0001);
    bus4.load      = 1'b0;
    bus3.load      = 1'b0;
    bus4.stage_sel = 2'd2;
    bus3.stage_sel = 2'd3;
    step();
    check_val("sel2_count",  64'(bus4.count_out), 64'hABCD);
    check_val("sel3_oor",    64'(bus3.count_out), 64'h0);
    bus4.clear     = 1'b1;
    bus3.stage_sel = 2'd1;
    step();
    check_val("sel2_pre_clear", 64'(bus4.count_out), 64'hABCD);
    check_val("sel1_count",     64'(bus3.count_out), 64'h2);
    bus4.clear = 1'b0;
    step();
    check_val("sel2_post_clear", 64'(bus4.count_out), 64'h0);

    // Up count with enable continues from the cleared chain
    bus4.enable = 1'b1;
    bus4.stage_sel = 2'd0;
    repeat (3) step();
    check_val("recount_full",  bus4.full_count, 64'h3);
    check_val("recount_count", 64'(bus4.count_out), 64'h2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
